// File: rtl/vector_slicer_if.sv
// rtl/vector_slicer_if.sv - word-in / slice-out handshake bundle for vector_slicer
interface vector_slicer_if #(
    parameter int WIDTH = 16,
    parameter int SLICE = 8
);
    localparam int NUM   = WIDTH / SLICE;
    localparam int IDX_W = $clog2(NUM);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_msb_first;
    logic             out_valid;
    logic             out_ready;
    logic [SLICE-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport slave (
        input  in_valid, in_data, in_msb_first, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output in_valid, in_data, in_msb_first, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/vector_slicer.sv
// rtl/vector_slicer.sv - splits each accepted word into NUM slices, MSB- or LSB-first
module vector_slicer #(
    parameter int WIDTH = 16,
    parameter int SLICE = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    vector_slicer_if.slave   sif,
    output logic [CNT_W-1:0] word_cnt
);
    localparam int NUM   = WIDTH / SLICE;
    localparam int IDX_W = $clog2(NUM);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                      state_q, state_d;
    logic [NUM-1:0][SLICE-1:0]   hold_q, hold_d;
    logic                        msb_q, msb_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic out_valid;
    logic out_last;
    logic xfer;
    logic last_xfer;
    logic in_ready;
    logic accept;

    // Outputs come straight from the hold register and slice pointer, so they
    // are stable whenever the pointer is not advancing.
    always_comb begin
        out_valid = (state_q == SEND);
        out_last  = out_valid && (msb_q ? (idx_q == '0) : (idx_q == TOP_IDX));
        xfer      = out_valid && sif.out_ready;
        last_xfer = xfer && out_last;
        in_ready  = rst_n && (!out_valid || last_xfer);
        accept    = sif.in_valid && in_ready;
    end

    assign sif.out_valid = out_valid;
    assign sif.out_last  = out_last;
    assign sif.out_data  = hold_q[idx_q];
    assign sif.out_idx   = idx_q;
    assign sif.in_ready  = in_ready;
    assign word_cnt      = cnt_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        msb_d   = msb_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        if (last_xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A new accept wins over the pointer step: it can only coincide with
        // the final slice, whose pointer value is no longer needed.
        if (accept) begin
            state_d = SEND;
            hold_d  = sif.in_data;
            msb_d   = sif.in_msb_first;
            idx_d   = sif.in_msb_first ? TOP_IDX : '0;
        end else if (last_xfer) begin
            state_d = IDLE;
        end else if (xfer) begin
            idx_d = msb_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            msb_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            msb_q   <= msb_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_vector_slicer.sv
// tb/tb_vector_slicer.sv - directed and model-checked bench for vector_slicer
module tb_vector_slicer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] wc16;
    logic [7:0]  wc32;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    vector_slicer_if #(.WIDTH(16), .SLICE(8)) s16 ();
    vector_slicer_if #(.WIDTH(32), .SLICE(8)) s32 ();

    vector_slicer #(.WIDTH(16), .SLICE(8), .CNT_W(16)) d16 (
        .clk(clk), .rst_n(rst_n), .sif(s16), .word_cnt(wc16)
    );
    vector_slicer #(.WIDTH(32), .SLICE(8), .CNT_W(8)) d32 (
        .clk(clk), .rst_n(rst_n), .sif(s32), .word_cnt(wc32)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model of the 16-bit instance: a queue of the slices still owed downstream.
    typedef struct {
        logic [7:0] d;
        logic       idx;
        logic       last;
    } slice_t;

    slice_t      q[$];
    logic [15:0] m_cnt = '0;
    bit          m_rdy;
    bit          e_rdy;
    int          m_k;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_cnt = '0;
        end else begin
            m_rdy = (q.size() == 0) || (s16.out_ready && q[0].last);
            if (q.size() != 0 && s16.out_ready) begin
                if (q[0].last) m_cnt = m_cnt + 16'd1;
                void'(q.pop_front());
            end
            if (s16.in_valid && m_rdy) begin
                for (int n = 0; n < 2; n++) begin
                    m_k = s16.in_msb_first ? 1 - n : n;
                    q.push_back('{d: s16.in_data[m_k*8 +: 8], idx: 1'(m_k), last: (n == 1)});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            e_rdy = rst_n && ((q.size() == 0) || (s16.out_ready && q[0].last));
            check("m_in_ready", 32'(s16.in_ready), 32'(e_rdy));
            check("m_out_valid", 32'(s16.out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("m_out_data", 32'(s16.out_data), 32'(q[0].d));
                check("m_out_idx", 32'(s16.out_idx), 32'(q[0].idx));
                check("m_out_last", 32'(s16.out_last), 32'(q[0].last));
            end
            check("m_word_cnt", 32'(wc16), 32'(m_cnt));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic exp16(input logic [7:0] d, input logic i, input logic l);
        @(negedge clk);
        check("d16_valid", 32'(s16.out_valid), 32'd1);
        check("d16_data", 32'(s16.out_data), 32'(d));
        check("d16_idx", 32'(s16.out_idx), 32'(i));
        check("d16_last", 32'(s16.out_last), 32'(l));
        nxt();
    endtask

    task automatic exp32(input logic [7:0] d, input logic [1:0] i, input logic l);
        @(negedge clk);
        check("d32_valid", 32'(s32.out_valid), 32'd1);
        check("d32_data", 32'(s32.out_data), 32'(d));
        check("d32_idx", 32'(s32.out_idx), 32'(i));
        check("d32_last", 32'(s32.out_last), 32'(l));
        nxt();
    endtask

    task automatic send16(input logic [15:0] d, input logic msb);
        s16.in_valid = 1'b1;
        s16.in_data = d;
        s16.in_msb_first = msb;
        nxt();
        s16.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s16.in_valid = 1'b0; s16.in_data = '0; s16.in_msb_first = 1'b0; s16.out_ready = 1'b1;
        s32.in_valid = 1'b0; s32.in_data = '0; s32.in_msb_first = 1'b0; s32.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(s16.in_ready), 32'd0);
        check("rst_out_valid", 32'(s16.out_valid), 32'd0);
        check("rst_out_data", 32'(s16.out_data), 32'd0);
        check("rst_word_cnt", 32'(wc16), 32'd0);
        nxt();
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(s16.in_ready), 32'd1);
        nxt();

        // MSB-first, then LSB-first of the same word
        send16(16'habcd, 1'b1);
        exp16(8'hab, 1'b1, 1'b0);
        exp16(8'hcd, 1'b0, 1'b1);
        @(negedge clk);
        check("cnt_after_w1", 32'(wc16), 32'd1);
        check("idle_valid", 32'(s16.out_valid), 32'd0);
        nxt();
        send16(16'habcd, 1'b0);
        exp16(8'hcd, 1'b0, 1'b0);
        exp16(8'hab, 1'b1, 1'b1);

        // Downstream stall holds the first slice and blocks input
        s16.out_ready = 1'b0;
        send16(16'hfedc, 1'b1);
        s16.in_data = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(s16.in_ready), 32'd0);
            exp16(8'hfe, 1'b1, 1'b0);
        end
        s16.out_ready = 1'b1;
        exp16(8'hfe, 1'b1, 1'b0);
        exp16(8'hdc, 1'b0, 1'b1);
        @(negedge clk);
        check("cnt_after_stall", 32'(wc16), 32'd3);
        nxt();

        // Back-to-back words with in_valid held high
        s16.in_valid = 1'b1; s16.in_data = 16'h00ff; s16.in_msb_first = 1'b1;
        nxt();
        s16.in_data = 16'hff00;
        exp16(8'h00, 1'b1, 1'b0);
        exp16(8'hff, 1'b0, 1'b1);
        s16.in_valid = 1'b0;
        exp16(8'hff, 1'b1, 1'b0);
        exp16(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check("cnt_after_b2b", 32'(wc16), 32'd5);
        nxt();

        // Reset mid-word discards the remainder
        send16(16'hbaaa, 1'b1);
        exp16(8'hba, 1'b1, 1'b0);
        rst_n = 1'b0;
        nxt();
        @(negedge clk);
        check("midrst_valid", 32'(s16.out_valid), 32'd0);
        check("midrst_data", 32'(s16.out_data), 32'd0);
        check("midrst_idx", 32'(s16.out_idx), 32'd0);
        check("midrst_last", 32'(s16.out_last), 32'd0);
        check("midrst_cnt", 32'(wc16), 32'd0);
        check("midrst_in_ready", 32'(s16.in_ready), 32'd0);
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_in_ready", 32'(s16.in_ready), 32'd1);
        nxt();
        send16(16'h0002, 1'b1);
        exp16(8'h00, 1'b1, 1'b0);
        exp16(8'h02, 1'b0, 1'b1);
        @(negedge clk);
        check("cnt_after_rst_word", 32'(wc16), 32'd1);
        nxt();

        // Random traffic judged by the model alone
        for (int i = 0; i < 60; i++) begin
            s16.in_valid = 1'($urandom_range(0, 1));
            s16.in_data = 16'($urandom);
            s16.in_msb_first = 1'($urandom_range(0, 1));
            s16.out_ready = 1'($urandom_range(0, 1));
            nxt();
        end
        s16.in_valid = 1'b0;
        s16.out_ready = 1'b1;
        repeat (4) nxt();

        // 32-bit instance: four slices, then counter wrap at 8 bits
        s32.in_valid = 1'b1; s32.in_data = 32'hdeadbeef; s32.in_msb_first = 1'b1;
        nxt();
        s32.in_valid = 1'b0;
        exp32(8'hde, 2'd3, 1'b0);
        exp32(8'had, 2'd2, 1'b0);
        exp32(8'hbe, 2'd1, 1'b0);
        exp32(8'hef, 2'd0, 1'b1);
        @(negedge clk);
        check("d32_cnt1", 32'(wc32), 32'd1);
        nxt();
        for (int i = 0; i < 254; i++) begin
            s32.in_valid = 1'b1;
            s32.in_data = $urandom;
            s32.in_msb_first = 1'($urandom_range(0, 1));
            nxt();
            s32.in_valid = 1'b0;
            repeat (4) nxt();
        end
        @(negedge clk);
        check("d32_cnt_max", 32'(wc32), 32'hff);
        nxt();
        s32.in_valid = 1'b1; s32.in_data = 32'h01020304; s32.in_msb_first = 1'b0;
        nxt();
        s32.in_valid = 1'b0;
        exp32(8'h04, 2'd0, 1'b0);
        exp32(8'h03, 2'd1, 1'b0);
        exp32(8'h02, 2'd2, 1'b0);
        exp32(8'h01, 2'd3, 1'b1);
        @(negedge clk);
        check("d32_cnt_wrap", 32'(wc32), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
